// File: rtl/hazard_forwarding_unit_pkg.sv
// rtl/hazard_forwarding_unit_pkg.sv - shared constants for the hazard/forwarding unit
package hazard_forwarding_unit_pkg;

  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  // Bit position of the register-file choice inside each operand's one-hot group
  localparam int FWD_REGFILE = 0;

  // Shadow entry layout: {valid, dst[ADDR_W-1:0], we, is_load}
  localparam int ENT_LOAD = 0;
  localparam int ENT_WE   = 1;
  localparam int ENT_DST  = 2;

  function automatic int ent_w(input int addr_w);
    return addr_w + 3;
  endfunction

endpackage

// File: rtl/hazard_shadow_stage.sv
// rtl/hazard_shadow_stage.sv - one shadow pipeline entry with per-operand tag match
module hazard_shadow_stage
  import hazard_forwarding_unit_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int OPS      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       shift,
  input  logic                       clear,
  input  logic [ent_w(ADDR_W)-1:0]   d,
  input  logic [OPS*ADDR_W-1:0]      src_addr,
  input  logic [OPS-1:0]             src_used,
  output logic [ent_w(ADDR_W)-1:0]   q,
  output logic [OPS-1:0]             match
);

  localparam int EW = ent_w(ADDR_W);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift) begin
      q <= d;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < OPS; i++) begin
      match[i] = q[EW-1] & q[ENT_WE] & src_used[i]
               & (q[ENT_DST +: ADDR_W] == src_addr[i*ADDR_W +: ADDR_W])
               & !((ZERO_REG != 0) && (src_addr[i*ADDR_W +: ADDR_W] == '0));
    end
  end

endmodule

// File: rtl/hazard_forwarding_unit.sv
// rtl/hazard_forwarding_unit.sv - decode-stage hazard detection and operand forwarding
module hazard_forwarding_unit
  import hazard_forwarding_unit_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int STAGES     = STG_MEMWB,
  parameter int OPS        = 2,
  parameter int LOAD_READY = STG_MEMWB,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       advance,
  input  logic                       flush,
  input  logic                       dec_valid,
  input  logic [OPS*ADDR_W-1:0]      dec_src_addr,
  input  logic [OPS-1:0]             dec_src_used,
  input  logic [ADDR_W-1:0]          dec_dst_addr,
  input  logic                       dec_dst_we,
  input  logic                       dec_is_load,
  output logic [OPS*(STAGES+1)-1:0]  fwd_sel,
  output logic                       stall_req,
  output logic [CNT_W-1:0]           stall_count
);

  localparam int EW    = ent_w(ADDR_W);
  localparam int SEL_W = STAGES + 1;

  // Index 0 is the decode slot itself, feeding entry 1
  logic [EW-1:0]  ent   [STAGES+1];
  logic [OPS-1:0] match [STAGES+1];

  assign ent[0]   = {dec_valid, dec_dst_addr, dec_dst_we, dec_is_load};
  assign match[0] = '0;

  for (genvar k = STG_IDEX; k <= STAGES; k++) begin : g_stage
    // A flush squashes decode (entry 1 load) and the instruction leaving entry 1
    logic clr;
    if (k == STG_IDEX) begin : g_clr_idex
      assign clr = flush | (advance & stall_req);
    end else if (k == STG_EXMEM) begin : g_clr_exmem
      assign clr = flush & advance;
    end else begin : g_clr_none
      assign clr = 1'b0;
    end

    hazard_shadow_stage #(
      .ADDR_W   (ADDR_W),
      .OPS      (OPS),
      .ZERO_REG (ZERO_REG)
    ) u_stage (
      .clock    (clock),
      .reset_n  (reset_n),
      .shift    (advance),
      .clear    (clr),
      .d        (ent[k-1]),
      .src_addr (dec_src_addr),
      .src_used (dec_src_used),
      .q        (ent[k]),
      .match    (match[k])
    );
  end

  always_comb begin
    int youngest;
    fwd_sel   = '0;
    stall_req = 1'b0;
    for (int i = 0; i < OPS; i++) begin
      youngest = FWD_REGFILE;
      for (int k = STAGES; k >= STG_IDEX; k--) begin
        if (match[k][i]) youngest = k;
      end
      if (!dec_valid) youngest = FWD_REGFILE;
      fwd_sel[i*SEL_W + youngest] = 1'b1;
      if (youngest != FWD_REGFILE && youngest < LOAD_READY && ent[youngest][ENT_LOAD]) begin
        stall_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall_req && advance && !(&stall_count)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// tb/tb_hazard_forwarding_unit.sv - self-checking bench for hazard_forwarding_unit
module tb_hazard_forwarding_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        advance = 1'b0;
  logic        flush = 1'b0;
  logic        dec_valid = 1'b0;
  logic [9:0]  dec_src_addr = '0;
  logic [1:0]  dec_src_used = '0;
  logic [4:0]  dec_dst_addr = '0;
  logic        dec_dst_we = 1'b0;
  logic        dec_is_load = 1'b0;
  logic [7:0]  fwd_sel, fwd_sel2;
  logic        stall_req, stall_req2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {bit v; bit [4:0] d; bit w; bit l;} ent_t;
  ent_t m[4];
  int   mcount = 0;

  hazard_forwarding_unit dut (
    .clock(clock), .reset_n(reset_n), .advance(advance), .flush(flush),
    .dec_valid(dec_valid), .dec_src_addr(dec_src_addr), .dec_src_used(dec_src_used),
    .dec_dst_addr(dec_dst_addr), .dec_dst_we(dec_dst_we), .dec_is_load(dec_is_load),
    .fwd_sel(fwd_sel), .stall_req(stall_req), .stall_count(stall_count)
  );

  hazard_forwarding_unit #(.CNT_W(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .advance(advance), .flush(flush),
    .dec_valid(dec_valid), .dec_src_addr(dec_src_addr), .dec_src_used(dec_src_used),
    .dec_dst_addr(dec_dst_addr), .dec_dst_we(dec_dst_we), .dec_is_load(dec_is_load),
    .fwd_sel(fwd_sel2), .stall_req(stall_req2), .stall_count(stall_count2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Youngest in-flight writer of each read operand; a load that is too young stalls
  function automatic void model_out(output logic [7:0] sel, output logic st);
    sel = '0;
    st  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      int         y = 0;
      logic [4:0] s = dec_src_addr[i*5 +: 5];
      if (dec_valid && dec_src_used[i] && s != 5'd0) begin
        for (int k = 1; k <= 3; k++) begin
          if (y == 0 && m[k].v && m[k].w && m[k].d == s) y = k;
        end
      end
      sel[i*4 + y] = 1'b1;
      if (y != 0 && y < 3 && m[y].l) st = 1'b1;
    end
  endfunction

  always @(posedge clock or negedge reset_n) begin
    logic [7:0] es;
    logic       est;
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) m[k] = '{0, 0, 0, 0};
      mcount = 0;
    end else begin
      model_out(es, est);
      if (advance) begin
        m[3] = m[2];
        m[2] = m[1];
        if (flush) begin
          m[1].v = 0;
          m[2].v = 0;
        end else if (est) begin
          m[1].v = 0;
        end else begin
          m[1] = '{dec_valid, dec_dst_addr, dec_dst_we, dec_is_load};
        end
        if (est && mcount < 65535) mcount++;
      end else if (flush) begin
        m[1].v = 0;
      end
    end
  end

  always @(negedge clock) begin
    logic [7:0] es;
    logic       est;
    model_out(es, est);
    chk("fwd_sel", fwd_sel, es);
    chk("stall_req", stall_req, est);
    chk("stall_count", stall_count, mcount);
    chk("stall_count_sat", stall_count2, (mcount > 3) ? 3 : mcount);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] s1, input logic [4:0] s0,
                         input logic [1:0] used, input logic [4:0] dst, input logic we,
                         input logic ld);
    dec_valid = v;
    dec_src_addr = {s1, s0};
    dec_src_used = used;
    dec_dst_addr = dst;
    dec_dst_we = we;
    dec_is_load = ld;
  endtask

  initial begin
    #1;
    chk("reset_fwd", fwd_sel, 8'h11);
    chk("reset_stall", stall_req, 1'b0);
    chk("reset_count", stall_count, 16'd0);
    #11 reset_n = 1'b1;
    advance = 1'b1;

    // ALU forward, then hold
    set_dec(1, 0, 3, 2'b00, 3, 1, 0);
    tick();
    set_dec(1, 0, 3, 2'b01, 7, 0, 0);
    #1 chk("alu_fwd", fwd_sel[3:0], 4'b0010);
    advance = 1'b0;
    tick();
    chk("alu_fwd_hold", fwd_sel[3:0], 4'b0010);
    advance = 1'b1;

    // Drain, then load-use
    set_dec(0, 0, 0, 2'b00, 0, 0, 0);
    tick(); tick(); tick();
    set_dec(1, 0, 0, 2'b00, 4, 1, 1);
    tick();
    set_dec(1, 0, 4, 2'b01, 9, 1, 0);
    #1 chk("lu_stall1", stall_req, 1'b1);
    tick();
    chk("lu_stall2", stall_req, 1'b1);
    tick();
    chk("lu_fwd", fwd_sel[3:0], 4'b1000);
    chk("lu_nostall", stall_req, 1'b0);
    chk("lu_count", stall_count, 16'd2);
    tick();

    // Second load-use to saturate the 2-bit counter
    set_dec(1, 0, 0, 2'b00, 4, 1, 1);
    tick();
    set_dec(1, 0, 4, 2'b01, 9, 1, 0);
    tick(); tick();
    chk("sat_count16", stall_count, 16'd4);
    chk("sat_count2", stall_count2, 2'd3);
    tick();

    // Youngest producer wins
    set_dec(1, 0, 0, 2'b00, 5, 1, 0);
    tick(); tick();
    set_dec(1, 5, 5, 2'b11, 8, 0, 0);
    #1 chk("youngest", fwd_sel, 8'h22);

    // Zero register and unused operands
    set_dec(1, 0, 0, 2'b00, 0, 1, 0);
    tick();
    set_dec(1, 0, 0, 2'b01, 8, 0, 0);
    #1 chk("zero_reg", fwd_sel[3:0], 4'b0001);
    set_dec(1, 0, 0, 2'b00, 7, 1, 1);
    tick();
    set_dec(1, 7, 7, 2'b00, 8, 0, 0);
    #1 chk("unused_fwd", fwd_sel, 8'h11);
    chk("unused_stall", stall_req, 1'b0);

    // Flush squashes the producer in entry 1
    set_dec(1, 0, 0, 2'b00, 6, 1, 0);
    tick();
    set_dec(1, 0, 0, 2'b00, 9, 1, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_dec(1, 9, 6, 2'b11, 8, 0, 0);
    #1 chk("flush", fwd_sel, 8'h11);

    // Asynchronous reset mid-stream
    set_dec(1, 0, 0, 2'b00, 2, 1, 0);
    tick(); tick();
    set_dec(1, 2, 2, 2'b11, 8, 0, 0);
    #1 chk("pre_reset", fwd_sel, 8'h22);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_reset_fwd", fwd_sel, 8'h11);
    chk("mid_reset_count", stall_count, 16'd0);
    chk("mid_reset_stall", stall_req, 1'b0);
    reset_n = 1'b1;
    tick();
    chk("post_reset", fwd_sel, 8'h11);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      set_dec($urandom_range(0, 7) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
              $urandom_range(0, 2) == 0);
      advance = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      tick();
    end

    @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
